// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer for a single-port 256 x 16 data
// memory. Port A is the core load/store stage and port B is the loader/debug
// port. At most one access is granted per cycle and it is driven straight onto
// the memory pins. Read data comes back one cycle later, tagged to the port
// that issued the read.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; contention resolved by fixed priority or round-robin
// ST_OWN_A | port A holds a lock; A wins whenever it requests
// ST_OWN_B | port B holds a lock; B wins whenever it requests
module dmem_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int MAX_LOCK   = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,

   input  logic        a_req_i,
   input  logic        a_we_i,
   input  logic [7:0]  a_addr_i,
   input  logic [15:0] a_wdata_i,
   input  logic        a_lock_i,
   output logic        a_gnt_o,
   output logic        a_rvalid_o,
   output logic [15:0] a_rdata_o,

   input  logic        b_req_i,
   input  logic        b_we_i,
   input  logic [7:0]  b_addr_i,
   input  logic [15:0] b_wdata_i,
   input  logic        b_lock_i,
   output logic        b_gnt_o,
   output logic        b_rvalid_o,
   output logic [15:0] b_rdata_o,

   output logic [7:0]  mem_address_o,
   output logic [15:0] mem_data_in_o,
   output logic        mem_write_en_o,
   input  logic [15:0] mem_data_out_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

   state_t      state_q, state_d;
   logic        last_b_q, last_b_d;      // 1 = port B won the most recent grant
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic [7:0]  addr_q;                  // last granted address, held on idle cycles
   logic        a_rvalid_q, b_rvalid_q;

   logic        gnt_a, gnt_b;
   logic        force_a, force_b;        // lock budget exhausted, waiting port forced in
   logic        lock_full;

   assign lock_full = (lock_cnt_q == LOCK_MAX);

   // Grant decision: purely combinational from requests and current state.
   always_comb begin
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      force_a = 1'b0;
      force_b = 1'b0;
      if (rst_n_i) begin
         case (state_q)
            ST_OWN_A: begin
               if (a_req_i && b_req_i && lock_full) begin
                  gnt_b   = 1'b1;
                  force_b = 1'b1;
               end else if (a_req_i) begin
                  gnt_a = 1'b1;
               end else if (b_req_i) begin
                  gnt_b = 1'b1;
               end
            end
            ST_OWN_B: begin
               if (a_req_i && b_req_i && lock_full) begin
                  gnt_a   = 1'b1;
                  force_a = 1'b1;
               end else if (b_req_i) begin
                  gnt_b = 1'b1;
               end else if (a_req_i) begin
                  gnt_a = 1'b1;
               end
            end
            default: begin
               if (a_req_i && b_req_i) begin
                  if ((FIXED_PRIO != 0) || last_b_q) begin
                     gnt_a = 1'b1;
                  end else begin
                     gnt_b = 1'b1;
                  end
               end else begin
                  gnt_a = a_req_i;
                  gnt_b = b_req_i;
               end
            end
         endcase
      end
   end

   // Next-state, lock budget and round-robin pointer.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      last_b_d   = last_b_q;
      if (gnt_a) begin
         last_b_d = 1'b0;
      end else if (gnt_b) begin
         last_b_d = 1'b1;
      end
      case (state_q)
         ST_OWN_A: begin
            if (force_b) begin
               state_d    = b_lock_i ? ST_OWN_B : ST_IDLE;
               lock_cnt_d = b_lock_i ? 8'd1 : 8'd0;
            end else begin
               if (gnt_a && !lock_full) begin
                  lock_cnt_d = lock_cnt_q + 8'd1;
               end
               if (!a_lock_i) begin
                  state_d    = ST_IDLE;
                  lock_cnt_d = 8'd0;
               end
            end
         end
         ST_OWN_B: begin
            if (force_a) begin
               state_d    = a_lock_i ? ST_OWN_A : ST_IDLE;
               lock_cnt_d = a_lock_i ? 8'd1 : 8'd0;
            end else begin
               if (gnt_b && !lock_full) begin
                  lock_cnt_d = lock_cnt_q + 8'd1;
               end
               if (!b_lock_i) begin
                  state_d    = ST_IDLE;
                  lock_cnt_d = 8'd0;
               end
            end
         end
         default: begin
            if (gnt_a && a_lock_i) begin
               state_d    = ST_OWN_A;
               lock_cnt_d = 8'd1;
            end else if (gnt_b && b_lock_i) begin
               state_d    = ST_OWN_B;
               lock_cnt_d = 8'd1;
            end else begin
               lock_cnt_d = 8'd0;
            end
         end
      endcase
   end

   // State register, held address and read-valid pipeline.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         last_b_q   <= 1'b1;
         lock_cnt_q <= 8'd0;
         addr_q     <= 8'd0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_b_q   <= last_b_d;
         lock_cnt_q <= lock_cnt_d;
         if (gnt_a || gnt_b) begin
            addr_q <= mem_address_o;
         end
         a_rvalid_q <= gnt_a & ~a_we_i;
         b_rvalid_q <= gnt_b & ~b_we_i;
      end
   end

   assign a_gnt_o = gnt_a;
   assign b_gnt_o = gnt_b;

   assign mem_address_o  = gnt_a ? a_addr_i  : (gnt_b ? b_addr_i  : addr_q);
   assign mem_data_in_o  = gnt_a ? a_wdata_i : (gnt_b ? b_wdata_i : 16'h0000);
   assign mem_write_en_o = (gnt_a & a_we_i) | (gnt_b & b_we_i);

   // A read granted just before reset must not report data while reset is held.
   assign a_rvalid_o = a_rvalid_q & rst_n_i;
   assign b_rvalid_o = b_rvalid_q & rst_n_i;

   // Both ports see the memory output; rvalid is the only qualifier.
   assign a_rdata_o = mem_data_out_i;
   assign b_rdata_o = mem_data_out_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances share stimulus (round-robin with a
// lock budget of 4, and fixed priority). Each drives its own memory model.
// The driver pushes expected grant/bus values and expected read returns into
// queues; a monitor on the falling edge pops and compares.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
   logic [7:0]  a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;

   logic        a_gnt0, b_gnt0, a_rv0, b_rv0, mwe0;
   logic [15:0] a_rd0, b_rd0, mdin0, dout0;
   logic [7:0]  maddr0;
   logic        a_gnt1, b_gnt1, a_rv1, b_rv1, mwe1;
   logic [15:0] a_rd1, b_rd1, mdin1, dout1;
   logic [7:0]  maddr1;

   logic [15:0] mem0 [256];
   logic [15:0] mem1 [256];

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;

   typedef struct {
      bit          sel;
      logic        ag;
      logic        bg;
      logic        we;
      logic [7:0]  addr;
      logic [15:0] din;
   } gexp_t;

   typedef struct {
      bit          port;
      logic [15:0] data;
      int          due;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   dmem_arbiter #(.FIXED_PRIO(0), .MAX_LOCK(4)) u0 (
      .clk_i(clk), .rst_n_i(rst_n),
      .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_lock_i(a_lock), .a_gnt_o(a_gnt0), .a_rvalid_o(a_rv0), .a_rdata_o(a_rd0),
      .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_lock_i(b_lock), .b_gnt_o(b_gnt0), .b_rvalid_o(b_rv0), .b_rdata_o(b_rd0),
      .mem_address_o(maddr0), .mem_data_in_o(mdin0), .mem_write_en_o(mwe0),
      .mem_data_out_i(dout0)
   );

   dmem_arbiter #(.FIXED_PRIO(1), .MAX_LOCK(16)) u1 (
      .clk_i(clk), .rst_n_i(rst_n),
      .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_lock_i(a_lock), .a_gnt_o(a_gnt1), .a_rvalid_o(a_rv1), .a_rdata_o(a_rd1),
      .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_lock_i(b_lock), .b_gnt_o(b_gnt1), .b_rvalid_o(b_rv1), .b_rdata_o(b_rd1),
      .mem_address_o(maddr1), .mem_data_in_o(mdin1), .mem_write_en_o(mwe1),
      .mem_data_out_i(dout1)
   );

   // Single-port memories with registered read data.
   always @(posedge clk) begin
      if (mwe0) mem0[maddr0] <= mdin0;
      dout0 <= mem0[maddr0];
      if (mwe1) mem1[maddr1] <= mdin1;
      dout1 <= mem1[maddr1];
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 16'h0000;
         mem1[i] = 16'h0000;
      end
      mem0[0] = 16'h0003;
      mem0[1] = 16'h0101;
      mem0[2] = 16'h0202;
      mem0[9] = 16'h1234;
      dout0 = 16'h0000;
      dout1 = 16'h0000;
   end

   // Monitor: grant/bus check every cycle, read-return check on rvalid (u0).
   gexp_t       e;
   rexp_t       r;
   logic [26:0] act, exv;
   logic [15:0] rd_act;
   always @(negedge clk) begin
      if (gq.size() > 0) begin
         e = gq.pop_front();
         exv = {e.ag, e.bg, e.we, e.addr, e.din};
         act = e.sel ? {a_gnt1, b_gnt1, mwe1, maddr1, mdin1}
                     : {a_gnt0, b_gnt0, mwe0, maddr0, mdin0};
         total++;
         if (act !== exv) begin
            bad++;
            $display("FAIL grant cyc=%0d dut=%0d got ag=%b bg=%b we=%b addr=%h din=%h want ag=%b bg=%b we=%b addr=%h din=%h",
                     cyc_cnt, e.sel, act[26], act[25], act[24], act[23:16], act[15:0],
                     e.ag, e.bg, e.we, e.addr, e.din);
         end
      end
      if (a_rv0 === 1'b1 && b_rv0 === 1'b1) begin
         total++;
         bad++;
         $display("FAIL dual_rvalid cyc=%0d got a_rvalid=1 b_rvalid=1 want at most one", cyc_cnt);
      end else if (a_rv0 === 1'b1 || b_rv0 === 1'b1) begin
         total++;
         rd_act = b_rv0 ? b_rd0 : a_rd0;
         if (rq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rvalid cyc=%0d got port=%0d data=%h want no rvalid",
                     cyc_cnt, b_rv0, rd_act);
         end else begin
            r = rq.pop_front();
            if (r.port !== b_rv0 || r.data !== rd_act || r.due != cyc_cnt) begin
               bad++;
               $display("FAIL rdata cyc=%0d got port=%0d data=%h want port=%0d data=%h cyc=%0d",
                        cyc_cnt, b_rv0, rd_act, r.port, r.data, r.due);
            end
         end
      end
      if (rq.size() > 0 && rq[0].due < cyc_cnt) begin
         r = rq.pop_front();
         total++;
         bad++;
         $display("FAIL missing_rvalid cyc=%0d got none want port=%0d data=%h at cyc=%0d",
                  cyc_cnt, r.port, r.data, r.due);
      end
   end

   // One cycle of stimulus: inputs already set by the caller.
   task automatic step(input bit sel, input logic ag, input logic bg, input logic we,
                       input logic [7:0] addr, input logic [15:0] din,
                       input bit rv, input logic [15:0] rd);
      gexp_t g;
      rexp_t x;
      g.sel = sel; g.ag = ag; g.bg = bg; g.we = we; g.addr = addr; g.din = din;
      gq.push_back(g);
      if (rv) begin
         x.port = bg;
         x.data = rd;
         x.due  = cyc_cnt + 1;
         rq.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 16'hBEEF; a_lock = 1'b0;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h06; b_wdata = 16'hCAFE; b_lock = 1'b0;
      @(posedge clk);
      #1;
      // Reset held with both requesting: no grants, no write strobe.
      step(0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0);
      step(1, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0);

      // Round-robin under continuous contention: A, B, A, B.
      rst_n = 1'b1;
      a_we = 1'b0; a_addr = 8'h09; a_wdata = 16'h0000;
      b_we = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000;
      step(0, 1, 0, 0, 8'h09, 16'h0000, 1, 16'h1234);
      step(0, 0, 1, 0, 8'h00, 16'h0000, 1, 16'h0003);
      step(0, 1, 0, 0, 8'h09, 16'h0000, 1, 16'h1234);
      step(0, 0, 1, 0, 8'h00, 16'h0000, 1, 16'h0003);
      a_req = 1'b0; b_req = 1'b0;
      step(0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0);

      // A writes 0x00AA to 5, B reads 5 the next cycle.
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 16'h00AA;
      step(0, 1, 0, 1, 8'h05, 16'h00AA, 0, 16'h0);
      a_req = 1'b0; a_we = 1'b0; a_wdata = 16'h0000;
      b_req = 1'b1; b_addr = 8'h05;
      step(0, 0, 1, 0, 8'h05, 16'h0000, 1, 16'h00AA);
      b_req = 1'b0;
      step(0, 0, 0, 0, 8'h05, 16'h0000, 0, 16'h0);

      // A reads preloaded address 0.
      a_req = 1'b1; a_addr = 8'h00;
      step(0, 1, 0, 0, 8'h00, 16'h0000, 1, 16'h0003);
      a_req = 1'b0;
      step(0, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0);

      // Lock budget of 4: B goes first so A wins the next tie, then 4A,B twice.
      b_req = 1'b1; b_addr = 8'h02;
      step(0, 0, 1, 0, 8'h02, 16'h0000, 1, 16'h0202);
      a_req = 1'b1; a_addr = 8'h01; a_lock = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 8'h01, 16'h0000, 1, 16'h0101);
         step(0, 0, 1, 0, 8'h02, 16'h0000, 1, 16'h0202);
      end
      a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0;
      step(0, 0, 0, 0, 8'h02, 16'h0000, 0, 16'h0);

      // Fixed priority instance: reset, then contended writes.
      rst_n = 1'b0;
      step(0, 0, 0, 0, 8'h02, 16'h0000, 0, 16'h0);
      rst_n = 1'b1;
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'h1111;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 16'h2222;
      for (int j = 0; j < 5; j++) step(1, 1, 0, 1, 8'h10, 16'h1111, 0, 16'h0);
      a_req = 1'b0;
      step(1, 0, 1, 1, 8'h20, 16'h2222, 0, 16'h0);
      b_req = 1'b0; a_we = 1'b0; b_we = 1'b0; a_wdata = 16'h0000; b_wdata = 16'h0000;
      step(1, 0, 0, 0, 8'h20, 16'h0000, 0, 16'h0);

      // Read granted, then reset: no rvalid; first tie afterwards goes to A.
      a_req = 1'b1; a_addr = 8'h09;
      step(0, 1, 0, 0, 8'h09, 16'h0000, 0, 16'h0);
      rst_n = 1'b0; a_req = 1'b0;
      step(0, 0, 0, 0, 8'h09, 16'h0000, 0, 16'h0);
      rst_n = 1'b1;
      a_req = 1'b1; b_req = 1'b1; b_addr = 8'h00;
      step(0, 1, 0, 0, 8'h09, 16'h0000, 1, 16'h1234);
      a_req = 1'b0; b_req = 1'b0;
      step(0, 0, 0, 0, 8'h09, 16'h0000, 0, 16'h0);
      step(0, 0, 0, 0, 8'h09, 16'h0000, 0, 16'h0);

      @(negedge clk);
      #1;
      total++;
      if (rq.size() != 0) begin
         bad++;
         $display("FAIL drain_rq got %0d pending reads want 0", rq.size());
      end
      total++;
      if (gq.size() != 0) begin
         bad++;
         $display("FAIL drain_gq got %0d pending checks want 0", gq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 256 x 16 data memory. Port A is the core load/store stage; port B is the loader/debug port.
- Grants at most one access per cycle and drives the memory's address, write-data and write-enable directly.
- Returns read data with the memory's fixed 1-cycle read latency, tagged to the requester that issued the read.
- Supports round-robin or fixed priority, and a per-port lock for back-to-back bursts.

Parameters:
- FIXED_PRIO, 0, 1 = port A always wins contention; 0 = round-robin.
- MAX_LOCK, 16, maximum consecutive grants to a locked owner before a waiting requester is forced in (1..255).

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- a_req  in  1  port A access request, held until a_gnt
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  8  port A word address
- a_wdata  in  16  port A write data
- a_lock  in  1  port A requests ownership across consecutive requests
- a_gnt  out  1  combinational; access accepted and issued to memory this cycle
- a_rvalid  out  1  registered; a_rdata valid (read granted previous cycle)
- a_rdata  out  16  read data for port A
- b_req, b_we, b_addr, b_wdata, b_lock, b_gnt, b_rvalid, b_rdata  same as port A, for port B
- mem_address  out  8  to memory address
- mem_data_in  out  16  to memory write data
- mem_write_en  out  1  to memory write enable
- mem_data_out  in  16  from memory registered read data

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, last_winner=B (A wins first round-robin tie), lock_cnt=0, a_rvalid=b_rvalid=0.
- While rst_n is low, a_gnt=b_gnt=0 and mem_write_en=0 combinationally.
- Reset mid-burst drops ownership; a read granted in the cycle before reset yields no rvalid.
- Grant is combinational from req and state; at most one of a_gnt/b_gnt is high per cycle.
- mem_address, mem_data_in and mem_write_en follow the granted port: mem_write_en = gnt & we.
- With no grant: mem_write_en=0, mem_address holds the last granted address, mem_data_in=0.
- Read latency: a read granted in cycle N gives x_rvalid=1 for exactly cycle N+1, with x_rdata = mem_data_out.
- a_rdata and b_rdata are both wired to mem_data_out; only rvalid qualifies them.
- A write grant produces no rvalid. A write to address X followed by a read of X in the next cycle returns the new value.
- FSM states:
  - IDLE: only one requester → it is granted. Both → FIXED_PRIO=1: A; else the port not equal to last_winner. Winner with lock=1 → OWN_A/OWN_B, lock_cnt=1.
  - OWN_A: A has priority whenever a_req=1, independent of FIXED_PRIO.
    - If a_req=0, B may be granted that cycle; ownership is kept while a_lock=1.
    - a_lock=0 at any cycle → IDLE after that cycle's grant.
    - lock_cnt increments on each A grant. When lock_cnt==MAX_LOCK and b_req=1, the next contended cycle grants B, lock_cnt clears and state → IDLE (or OWN_B if b_lock).
  - OWN_B: symmetric.
- last_winner updates on every grant.
- Requesters must hold req, we, addr, wdata stable until gnt. A request dropped before grant is simply not served.
- A port may request again in the cycle its gnt is high; the same port is granted every cycle if uncontested (full throughput, 1 access/cycle).
- Addresses are 8-bit; no wrap or bounds logic is needed.

Test Plan:
- Reset with both req=1: no gnt, mem_write_en=0. After release, A granted first; round-robin alternates A,B,A,B over 4 cycles of continuous contention.
- A writes 0x00AA to addr 5; next cycle B reads addr 5 → b_rvalid=1 one cycle later, b_rdata=0x00AA, a_rvalid stays 0.
- Read of addr 0 after preload → a_rvalid high exactly one cycle after a_gnt, a_rdata=0x0003.
- FIXED_PRIO=1, both requesting continuously for 5 cycles → only a_gnt high; B granted in the first cycle A drops req.
- MAX_LOCK=4, a_lock=1, a_req and b_req held high → A granted 4 consecutive cycles, then B granted, then state returns to IDLE.
- rst_n asserted one cycle after a read grant → no rvalid, state IDLE. The first grant after reset follows round-robin reset order (A).
